// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point mode constants and the rescale/round/overflow helper
package fxp_pkg;
  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int OVF_WRAP    = 0;
  localparam int OVF_SAT     = 1;
  // Returns {ovf, data} packed so that truncating the result to width+1 bits
  // leaves ovf at bit [width] and data in [width-1:0].
  function automatic logic [64:0] fxp_scale(input logic signed [127:0] p, input int width,
                                            input int frac, input int round, input int sat);
    logic signed [128:0] r, s, hi, lo;
    logic ovf;
    logic [64:0] ret;
    r = {p[127], p};
    r = (round == RND_HALF_UP && frac > 0) ? r + (129'sd1 <<< (frac - 1)) : r;
    s = r >>> frac;
    hi = (129'sd1 <<< (width - 1)) - 129'sd1;
    lo = -(129'sd1 <<< (width - 1));
    ovf = s > hi || s < lo;
    s = (sat == OVF_SAT && ovf) ? (s > hi ? hi : lo) : s;
    ret = {1'b0, s[63:0]};
    ret[width] = ovf;
    return ret;
  endfunction
endpackage

// File: rtl/fxp_pipe_slot.sv
// fxp_pipe_slot: one valid/ready register slot with a W-bit payload
// ports: clock, reset (async active-low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream
module fxp_pipe_slot
  import fxp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign in_ready = !valid_q || out_ready;
  always_comb begin
    valid_d = in_ready ? in_valid : valid_q;
    data_d = (in_ready && in_valid) ? in_data : data_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
endmodule

// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe: pipelined signed fixed-point multiplier with rounding, saturation and backpressure
// ports: clock, reset (async active-low); in_valid/in_ready/in_a/in_b operand pair;
//        out_valid/out_ready/out_data/out_ovf result; ovf_sticky flag cleared by ovf_clr
module fxp_mul_pipe
  import fxp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 12,
  parameter int STAGES = 3,
  parameter int ROUND  = RND_TRUNC,
  parameter int SAT    = OVF_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);
  localparam int PW = 2 * WIDTH;
  logic [STAGES:0] vld;
  logic [PW-1:0] pd [STAGES];
  logic signed [PW-1:0] a_x, b_x;
  logic [WIDTH:0] res, last_q;
  logic ovf_q, ovf_d;
  assign a_x = {{WIDTH{in_a[WIDTH-1]}}, in_a};
  assign b_x = {{WIDTH{in_b[WIDTH-1]}}, in_b};
  assign pd[0] = a_x * b_x;
  assign res = (WIDTH + 1)'(fxp_scale(128'($signed(pd[STAGES-1])), WIDTH, FRAC, ROUND, SAT));
  assign vld[0] = in_valid;
  // Each stage keeps its own ready net so the ready chain runs through distinct signals.
  genvar g;
  for (g = 0; g < STAGES; g++) begin : stg
    logic up;
    if (g < STAGES - 1) begin : mid
      fxp_pipe_slot #(.W(PW)) u_slot (
        .clock(clock), .reset(reset),
        .in_valid(vld[g]), .in_ready(up), .in_data(pd[g]),
        .out_valid(vld[g+1]), .out_ready(stg[g+1].up), .out_data(pd[g+1])
      );
    end else begin : last
      fxp_pipe_slot #(.W(WIDTH + 1)) u_slot (
        .clock(clock), .reset(reset),
        .in_valid(vld[g]), .in_ready(up), .in_data(res),
        .out_valid(vld[g+1]), .out_ready(out_ready), .out_data(last_q)
      );
    end
  end
  assign in_ready = stg[0].up;
  assign out_valid = vld[STAGES];
  assign {out_ovf, out_data} = last_q;
  assign ovf_d = (out_valid && out_ready && out_ovf) || (ovf_q && !ovf_clr);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_fxp_mul_pipe.sv
// tb_fxp_mul_pipe: randomized and directed checks of fxp_mul_pipe against an arithmetic model
module tb_fxp_mul_pipe;
  localparam int N = 5;
  localparam int STG [N] = '{3, 3, 2, 6, 3};
  localparam int FR  [N] = '{12, 12, 12, 12, 0};
  localparam int RN  [N] = '{0, 1, 0, 0, 0};
  localparam int SA  [N] = '{0, 1, 0, 0, 1};
  logic clock = 0, reset = 0, in_valid = 0, out_ready = 0, ovf_clr = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic ir [N], ov [N], oo [N], st [N];
  logic [31:0] od [N];
  logic [32:0] q [N][$];
  logic prev_stall [N];
  logic [33:0] hold [N];
  logic [32:0] e_m;
  int n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  fxp_mul_pipe #(.WIDTH(32), .FRAC(12), .STAGES(3), .ROUND(0), .SAT(0)) u0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ovf(oo[0]),
    .ovf_sticky(st[0]), .ovf_clr(ovf_clr));
  fxp_mul_pipe #(.WIDTH(32), .FRAC(12), .STAGES(3), .ROUND(1), .SAT(1)) u1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ovf(oo[1]),
    .ovf_sticky(st[1]), .ovf_clr(ovf_clr));
  fxp_mul_pipe #(.WIDTH(32), .FRAC(12), .STAGES(2), .ROUND(0), .SAT(0)) u2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_ovf(oo[2]),
    .ovf_sticky(st[2]), .ovf_clr(ovf_clr));
  fxp_mul_pipe #(.WIDTH(32), .FRAC(12), .STAGES(6), .ROUND(0), .SAT(0)) u3 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_ovf(oo[3]),
    .ovf_sticky(st[3]), .ovf_clr(ovf_clr));
  fxp_mul_pipe #(.WIDTH(32), .FRAC(0), .STAGES(3), .ROUND(0), .SAT(1)) u4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[4]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]), .out_ovf(oo[4]),
    .ovf_sticky(st[4]), .ovf_clr(ovf_clr));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input int fr, input int rn, input int sa);
    longint p, s;
    logic ovf;
    logic [31:0] d;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rn == 1 && fr > 0) p = p + (longint'(1) <<< (fr - 1));
    s = p >>> fr;
    ovf = s > 64'sd2147483647 || s < -64'sd2147483648;
    d = s[31:0];
    if (sa == 1 && ovf) d = s < 0 ? 32'h8000_0000 : 32'h7fff_ffff;
    return {ovf, d};
  endfunction
  function automatic logic [31:0] rnd();
    logic [31:0] x, y;
    x = $urandom;
    y = $urandom;
    return y[0] ? x : {{18{x[13]}}, x[13:0]};
  endfunction
  // Scoreboard: transfers seen at the negedge take effect on the following posedge.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        q[i].delete();
        prev_stall[i] = 0;
      end else begin
        if (prev_stall[i]) chk($sformatf("hold%0d", i), 64'({ov[i], oo[i], od[i]}), 64'(hold[i]));
        if (ov[i] && out_ready) begin
          if (q[i].size() == 0) chk($sformatf("spurious%0d", i), 64'(ov[i]), 64'(0));
          else begin
            e_m = q[i].pop_front();
            chk($sformatf("data%0d", i), 64'(od[i]), 64'(e_m[31:0]));
            chk($sformatf("ovf%0d", i), 64'(oo[i]), 64'(e_m[32]));
          end
        end
        if (in_valid && ir[i]) q[i].push_back(model(in_a, in_b, FR[i], RN[i], SA[i]));
        prev_stall[i] = ov[i] && !out_ready;
        hold[i] = {ov[i], oo[i], od[i]};
      end
    end
  end
  task automatic one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e0,
                     input logic [31:0] e1, input logic [31:0] ef, input logic cf);
    int lat [N];
    logic [31:0] gd [N];
    for (int i = 0; i < N; i++) begin
      lat[i] = 0;
      gd[i] = 0;
    end
    @(posedge clock); #1;
    in_a = a; in_b = b; in_valid = 1; out_ready = 1;
    @(posedge clock); #1;
    in_valid = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++)
        if (ov[i] && lat[i] == 0) begin
          lat[i] = c;
          gd[i] = od[i];
        end
      @(posedge clock); #1;
    end
    for (int i = 0; i < N; i++) chk($sformatf("lat%0d", i), 64'(lat[i]), 64'(STG[i]));
    chk("d_u0", 64'(gd[0]), 64'(e0));
    chk("d_u1", 64'(gd[1]), 64'(e1));
    chk("d_st2", 64'(gd[2]), 64'(e0));
    chk("d_st6", 64'(gd[3]), 64'(e0));
    if (cf) chk("d_f0", 64'(gd[4]), 64'(ef));
  endtask
  initial begin
    logic hit;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_valid%0d", i), 64'(ov[i]), 64'(0));
      chk($sformatf("rst_data%0d", i), 64'(od[i]), 64'(0));
      chk($sformatf("rst_ovf%0d", i), 64'(oo[i]), 64'(0));
      chk($sformatf("rst_sticky%0d", i), 64'(st[i]), 64'(0));
    end
    @(posedge clock); #1;
    reset = 1;
    @(negedge clock);
    for (int i = 0; i < N; i++) chk($sformatf("ready_after_rst%0d", i), 64'(ir[i]), 64'(1));
    one(32'h0000_3000, 32'h0000_2000, 32'h0000_6000, 32'h0000_6000, 32'h0, 1'b0);
    one(32'hFFFF_E800, 32'h0000_2000, 32'hFFFF_D000, 32'hFFFF_D000, 32'h0, 1'b0);
    one(32'h0000_0001, 32'h0000_0800, 32'h0000_0000, 32'h0000_0001, 32'h0, 1'b0);
    one(32'hFFFF_FFFF, 32'h0000_0800, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b0);
    one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFF0_0000, 32'h7FFF_FFFF, 32'h0, 1'b0);
    chk("sticky_u0", 64'(st[0]), 64'(1));
    chk("sticky_u1", 64'(st[1]), 64'(1));
    one(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    // overflow transfer coinciding with ovf_clr: set must win
    @(posedge clock); #1;
    in_a = 32'h7FFF_FFFF; in_b = 32'h7FFF_FFFF; in_valid = 1;
    @(posedge clock); #1;
    in_valid = 0;
    hit = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (ov[0]) begin
        hit = 1;
        break;
      end
    end
    chk("ovf_seen", 64'(hit), 64'(1));
    ovf_clr = 1;
    @(posedge clock); #1;
    ovf_clr = 0;
    chk("sticky_set_wins", 64'(st[0]), 64'(1));
    repeat (8) @(posedge clock);
    #1 ovf_clr = 1;
    @(posedge clock); #1;
    ovf_clr = 0;
    chk("sticky_clr_u0", 64'(st[0]), 64'(0));
    chk("sticky_clr_st6", 64'(st[3]), 64'(0));
    // fill under full backpressure: each pipe holds exactly STAGES results
    out_ready = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      in_valid = 1; in_a = rnd(); in_b = rnd();
    end
    @(posedge clock); #1;
    in_valid = 0;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("held%0d", i), 64'(q[i].size()), 64'(STG[i]));
      chk($sformatf("ready_full%0d", i), 64'(ir[i]), 64'(0));
    end
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid = $urandom_range(0, 3) != 0;
      in_a = rnd(); in_b = rnd();
    end
    @(posedge clock); #1;
    in_valid = 0; out_ready = 1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < N; i++) chk($sformatf("drained%0d", i), 64'(q[i].size()), 64'(0));
    // reset with results in flight
    one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFF0_0000, 32'h7FFF_FFFF, 32'h0, 1'b0);
    chk("sticky_pre_rst", 64'(st[0]), 64'(1));
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      in_valid = 1; in_a = rnd(); in_b = rnd();
    end
    @(posedge clock); #1;
    in_valid = 0;
    reset = 0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("arst_valid%0d", i), 64'(ov[i]), 64'(0));
      chk($sformatf("arst_sticky%0d", i), 64'(st[i]), 64'(0));
    end
    chk("arst_data", 64'(od[0]), 64'(0));
    @(posedge clock); #1;
    reset = 1;
    out_ready = 1;
    one(32'h0000_3000, 32'h0000_2000, 32'h0000_6000, 32'h0000_6000, 32'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fxp_mul_pipe.md
Name: fxp_mul_pipe

Overview:
- Pipelined signed fixed-point multiplier: Q-format product of two WIDTH-bit operands, rescaled by FRAC bits, back to WIDTH bits.
- Adds selectable rounding, saturation, overflow flags and valid/ready flow control with backpressure.
- Used in datapath test designs and DSP-style blocks wherever a registered, stall-able fixed-point multiply is needed.

Parameters:
- WIDTH, 32, operand and result width in bits (signed, two's complement); legal range 4..64.
- FRAC, 12, fraction bits; product is arithmetically shifted right by FRAC; legal range 0..WIDTH-1.
- STAGES, 3, pipeline depth (input-to-output latency in cycles); legal range 2..6.
- ROUND, 0, rounding mode: 0 = truncate toward -inf, 1 = round half up (add 2^(FRAC-1) before shift; no effect when FRAC=0).
- SAT, 0, overflow mode: 0 = wrap (keep low WIDTH bits), 1 = clamp to signed max/min.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- in_a  in  WIDTH  signed operand A
- in_b  in  WIDTH  signed operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  signed scaled product
- out_ovf  out  1  this result overflowed WIDTH (qualified by out_valid)
- ovf_sticky  out  1  set by any accepted result with out_ovf=1
- ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits 0, out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0. in_ready is 1 once reset deasserts.
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready. in_data stays don't-care while in_valid=0.
- Pipeline: STAGES register slots, each holding a valid bit and payload.
- Stage k loads from stage k-1 when slot k is empty or slot k advances (k+1 loads, or out_ready for the last slot).
- in_ready = slot 1 empty or slot 1 advancing. in_ready is combinational from out_ready through the chain; no combinational in->out data path.
- Latency is exactly STAGES cycles with out_ready held 1.
- Throughput is 1 per cycle. Bubbles collapse under backpressure, so the pipe holds up to STAGES results.
- Stall: when the last slot holds out_valid=1 and out_ready=0, out_data and out_ovf are held stable.
- Stage 1 registers the full signed 2*WIDTH product.
- Stages 2..STAGES-1 only delay the product.
- Last stage performs rounding, shift and overflow handling, then registers the result.
- Arithmetic, with p = signed product (2*WIDTH bits):
  - r = p + 2^(FRAC-1) if ROUND=1 and FRAC>0, else p; the add is computed in 2*WIDTH+1 bits (no internal wrap).
  - s = r >>> FRAC (arithmetic shift).
  - ovf = s outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=1: out_data = clamp(s), out_ovf = ovf.
  - SAT=0: out_data = s[WIDTH-1:0], out_ovf = ovf (flag still reported).
  - ROUND=0, SAT=0 reproduces truncation of product bits [WIDTH+FRAC-1:FRAC].
- ovf_sticky: set on an output transfer with out_ovf=1; cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: in-flight results are discarded, with no partial output afterwards.
- Boundary case, (-2^(WIDTH-1)) * (-2^(WIDTH-1)) with FRAC=0: must flag ovf (SAT=1 gives max, SAT=0 gives the low bits).

Decomposition:
- Shared package fxp_pkg:
  - mode constants RND_TRUNC/RND_HALF_UP and OVF_WRAP/OVF_SAT;
  - function fxp_scale(p, WIDTH, FRAC, ROUND, SAT) returning {ovf, data}; reusable by future fxp_add/fxp_mac.
- One sub-module, fxp_pipe_slot: a generic valid/ready register slot (payload width parameter), instantiated STAGES times.
- The multiply and fxp_scale stay in the top module.

Test Plan (WIDTH=32, FRAC=12, STAGES=3 unless stated):
- Basic: a=0x00003000 (3.0), b=0x00002000 (2.0), out_ready=1 -> out_data=0x00006000, out_ovf=0, out_valid exactly 3 cycles after the accept; a=0xFFFFE800 (-1.5), b=0x00002000 -> 0xFFFFD000.
- Rounding: a=0x00000001, b=0x00000800 -> ROUND=0: 0x00000000. ROUND=1: 0x00000001. For a=0xFFFFFFFF, b=0x00000800 -> ROUND=0: 0xFFFFFFFF. ROUND=1: 0x00000000.
- Overflow: a=b=0x7FFFFFFF -> SAT=0: out_data=0xFFF00000, out_ovf=1. SAT=1: 0x7FFFFFFF, out_ovf=1. ovf_sticky=1 after the transfer; pulse ovf_clr together with a second overflow result -> ovf_sticky stays 1.
- Backpressure: stream 8 back-to-back pairs while out_ready toggles 1,0,0,1,... (random) -> in_ready drops after 3 results are held. No loss or duplication; results arrive in order; out_data is stable during the stall.
- Reset mid-stream: assert reset with 3 results in flight -> out_valid=0 and ovf_sticky=0 immediately (asynchronous). The first output after reset release comes from a newly accepted pair only.
- STAGES=2 and STAGES=6 regression: same vectors as the Basic case -> latency 2 and 6 cycles, identical data.
